// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Latency: grant edge -> tx_start/ack next cycle; frame end -> next tx_start in GAP_CYCLES+2.
// Backpressure: req held until ack; req ignored outside IDLE; tx_busy gates frame completion.
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                 clk_top,
    input  logic                 rst_top,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 sched_busy,
    output logic [2:0]           active_id,
    output logic                 err_timeout
);

    localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_ID  = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [2:0]         active_id_q, active_id_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic               sched_busy_q, sched_busy_d;
    logic               err_timeout_q, err_timeout_d;

    logic [7:0] req_ext;
    logic [2:0] cand;
    logic       grant_vld;
    logic [2:0] grant_id;
    logic [7:0] grant_byte;

    // The round-robin pointer is the last granted id; search starts one past it.
    always_comb begin
        req_ext   = 8'(req);
        cand      = 3'd0;
        grant_vld = 1'b0;
        grant_id  = active_id_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 3'((int'(active_id_q) + k) % NUM_REQ);
            if (!grant_vld && req_ext[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
        grant_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                grant_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        active_id_d   = active_id_q;
        ack_d         = '0;
        tx_start_d    = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d     = ST_START;
                    tx_data_d   = grant_byte;
                    active_id_d = grant_id;
                    tx_start_d  = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ack_d[i] = (grant_id == 3'(i));
                    end
                end
            end
            ST_START: begin
                // One less than the limit so the error lands BUSY_TIMEOUT cycles after tx_start.
                state_d = ST_WAIT_BUSY;
                cnt_d   = TO_LOAD;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        sched_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_top or posedge rst_top) begin
        if (rst_top) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tx_data_q     <= 8'h00;
            active_id_q   <= LAST_ID;
            ack_q         <= '0;
            tx_start_q    <= 1'b0;
            sched_busy_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            active_id_q   <= active_id_d;
            ack_q         <= ack_d;
            tx_start_q    <= tx_start_d;
            sched_busy_q  <= sched_busy_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign sched_busy  = sched_busy_q;
    assign active_id   = active_id_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: vector table of single frames plus hand sequences for timeout and reset.
// Latency: checks grant->tx_start, gap length and timeout distance in clk_top cycles.
// Backpressure: a transmitter stub drives tx_busy; producers hold req per table row.
module tb_uart_tx_sched;

    localparam int NUM_REQ      = 4;
    localparam int GAP_CYCLES   = 16;
    localparam int BUSY_TIMEOUT = 64;

    logic                 clk_top;
    logic                 rst_top;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 sched_busy;
    logic [2:0]           active_id;
    logic                 err_timeout;

    int n_checks;
    int n_fail;

    uart_tx_sched #(
        .NUM_REQ      (NUM_REQ),
        .GAP_CYCLES   (GAP_CYCLES),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk_top     (clk_top),
        .rst_top     (rst_top),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .sched_busy  (sched_busy),
        .active_id   (active_id),
        .err_timeout (err_timeout)
    );

    initial clk_top = 1'b0;
    always #5 clk_top = ~clk_top;

    typedef struct {
        logic [3:0]  req_mask;
        logic [31:0] data;
        logic [2:0]  exp_id;
        logic [7:0]  exp_byte;
        int          busy_len;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},        32'(ack),         32'h0);
        chk({tag, "_tx_start"},   32'(tx_start),    32'h0);
        chk({tag, "_tx_data"},    32'(tx_data),     32'h00);
        chk({tag, "_sched_busy"}, 32'(sched_busy),  32'h0);
        chk({tag, "_active_id"},  32'(active_id),   32'd3);
        chk({tag, "_err"},        32'(err_timeout), 32'h0);
    endtask

    // Waits for tx_start; the grant edge is expected to be the very next edge.
    task automatic wait_start(input logic [2:0] exp_id, input logic [7:0] exp_byte);
        int n;
        logic [3:0] exp_ack;
        n = 0;
        do begin
            @(posedge clk_top); #1;
            n++;
        end while (!tx_start && n < 40);
        exp_ack = 4'b0001 << exp_id;
        chk("grant_latency", 32'(n),          32'd1);
        chk("ack_onehot",    32'(ack),        32'(exp_ack));
        chk("tx_data",       32'(tx_data),    32'(exp_byte));
        chk("active_id",     32'(active_id),  32'(exp_id));
        chk("busy_at_start", 32'(sched_busy), 32'd1);
    endtask

    task automatic run_frame(input logic [2:0] exp_id, input logic [7:0] exp_byte, input int busy_len);
        int n;
        wait_start(exp_id, exp_byte);
        @(posedge clk_top); #1;
        chk("start_pulse_width", 32'({tx_start, ack}), 32'h0);
        tx_busy = 1'b1;
        repeat (busy_len) begin
            @(posedge clk_top); #1;
        end
        chk("no_restart_in_frame", 32'(tx_start), 32'h0);
        tx_busy = 1'b0;
        n = 0;
        do begin
            @(posedge clk_top); #1;
            n++;
        end while (sched_busy && n < 100);
        chk("gap_len",     32'(n),       32'(GAP_CYCLES + 1));
        chk("tx_data_hold", 32'(tx_data), 32'(exp_byte));
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;

        tbl[0]  = '{4'b1111, 32'h44434241, 3'd0, 8'h41, 10};
        tbl[1]  = '{4'b1111, 32'h44434241, 3'd1, 8'h42, 3};
        tbl[2]  = '{4'b1111, 32'h44434241, 3'd2, 8'h43, 1};
        tbl[3]  = '{4'b1111, 32'h44434241, 3'd3, 8'h44, 20};
        tbl[4]  = '{4'b1111, 32'h44434241, 3'd0, 8'h41, 5};
        tbl[5]  = '{4'b1001, 32'h44434241, 3'd3, 8'h44, 7};
        tbl[6]  = '{4'b1001, 32'h44434241, 3'd0, 8'h41, 2};
        tbl[7]  = '{4'b1001, 32'h44434241, 3'd3, 8'h44, 8};
        tbl[8]  = '{4'b0001, 32'h4443426D, 3'd0, 8'h6D, 6};
        tbl[9]  = '{4'b0110, 32'hD3C2B1A0, 3'd1, 8'hB1, 4};
        tbl[10] = '{4'b0110, 32'hD3C2B1A0, 3'd2, 8'hC2, 9};
        tbl[11] = '{4'b0100, 32'hD3C2B1A0, 3'd2, 8'hC2, 3};

        rst_top  = 1'b1;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        repeat (2) @(posedge clk_top);
        #1;
        chk_reset_outputs("reset");
        rst_top = 1'b0;
        @(posedge clk_top); #1;
        chk("idle_no_req", 32'(sched_busy), 32'h0);

        // Contention, round-robin wrap and single-request rows.
        for (int i = 0; i < 12; i++) begin
            req      = tbl[i].req_mask;
            req_data = tbl[i].data;
            run_frame(tbl[i].exp_id, tbl[i].exp_byte, tbl[i].busy_len);
        end
        req = '0;

        // Busy never rises: error pulse BUSY_TIMEOUT cycles after tx_start.
        req      = 4'b0001;
        req_data = 32'h0000005A;
        wait_start(3'd0, 8'h5A);
        req = '0;
        n = 0;
        do begin
            @(posedge clk_top); #1;
            n++;
        end while (!err_timeout && n < 200);
        chk("timeout_latency",   32'(n),          32'(BUSY_TIMEOUT));
        chk("timeout_idle",      32'(sched_busy), 32'h0);
        @(posedge clk_top); #1;
        chk("timeout_pulse_width", 32'(err_timeout), 32'h0);
        chk("timeout_stay_idle",   32'(sched_busy),  32'h0);

        // tx_busy while idle must not start anything.
        tx_busy = 1'b1;
        repeat (5) @(posedge clk_top);
        #1;
        chk("idle_busy_ignored", 32'({sched_busy, tx_start}), 32'h0);
        tx_busy = 1'b0;

        // Reset in WAIT_DONE: outputs clear immediately, pointer restarts.
        req      = 4'b0010;
        req_data = 32'h00007700;
        wait_start(3'd1, 8'h77);
        req = '0;
        @(posedge clk_top); #1;
        tx_busy = 1'b1;
        repeat (3) @(posedge clk_top);
        #3;
        rst_top = 1'b1;
        #1;
        chk_reset_outputs("midframe_reset");
        tx_busy  = 1'b0;
        req      = 4'b0100;
        req_data = 32'h00990000;
        @(posedge clk_top); #1;
        rst_top = 1'b0;
        run_frame(3'd2, 8'h99, 4);
        req = '0;
        repeat (2) @(posedge clk_top);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
- Arbitrates requests and latches the winner's byte.
- Issues a one-cycle start pulse to the transmitter, tracks its busy flag to frame completion, and enforces an optional idle gap between frames.
- Sits between producer blocks and the uart_tx top, driving its start/data_in pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk_top cycles inserted after each frame before the next grant; 0 = no gap.
- BUSY_TIMEOUT, 64, max cycles to wait for tx_busy to rise after tx_start before abandoning the frame.

Ports:
- clk_top  in  1  system clock, rising edge.
- rst_top  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until matching ack.
- req_data  in  8*NUM_REQ  byte per requester; requester i on bits [8i+7:8i]; stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  8  byte to transmitter; held from grant until next grant.
- tx_busy  in  1  transmitter busy flag; high from shortly after start to end of stop bit.
- sched_busy  out  1  high whenever state != IDLE.
- active_id  out  3  index of last granted requester.
- err_timeout  out  1  one-cycle pulse when BUSY_TIMEOUT expires.

Behaviour:
- Reset (async, immediate): state=IDLE; ack=0, tx_start=0, tx_data=0x00, sched_busy=0, active_id=NUM_REQ-1, err_timeout=0; rr pointer=NUM_REQ-1; counters=0. Reset mid-frame aborts silently, no ack/err.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP. All outputs registered.
- IDLE: at an edge with req!=0, grant the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap. Latch its byte into tx_data; ptr and active_id take the winner; go START. req=0: stay.
- START (exactly 1 cycle): tx_start=1, ack[winner]=1; load the timeout counter; go WAIT_BUSY. Grant-edge to tx_start latency = 1 cycle.
- WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Otherwise decrement the counter; BUSY_TIMEOUT cycles elapsed without busy -> err_timeout pulse 1 cycle, go IDLE with no gap. The byte is already acked and is not retried.
- WAIT_DONE: tx_busy=0 -> GAP if GAP_CYCLES>0 (load counter), else IDLE.
- GAP: count GAP_CYCLES cycles, then IDLE. req is ignored in GAP, START, WAIT_*.
- Back-to-back: the earliest next grant edge is the first IDLE edge. Frame-end to next tx_start = GAP_CYCLES+2 cycles.
- Simultaneous requests: strict round robin. A requester still asserting after ack gets its next turn only after all other pending requesters.
- Wrap-around: ptr=NUM_REQ-1 searches from 0.
- Requester drops req before ack: legal only in IDLE before the grant edge. After the grant the latched byte is sent regardless.
- tx_busy high while in IDLE/GAP: ignored. tx_start is never reasserted before the WAIT_DONE->GAP/IDLE exit.
- At most one ack bit is high in any cycle; ack and tx_start are always coincident.

Test Plan:
- Reset: assert rst_top between edges -> all outputs at reset values immediately; active_id=3, tx_data=0x00.
- Single request: req=4'b0001, data0="m" (0x6D) -> next cycle tx_start=1 and ack=4'b0001 for 1 cycle, tx_data=0x6D. Transmitter serializes 0x6D, tx_busy falls, then 16 gap cycles, then sched_busy=0.
- Contention: req=4'b1111 held, data i = 0x41+i -> grant order 0,1,2,3,0 with tx_data 0x41,0x42,0x43,0x44,0x41. Exactly one ack per frame; frame spacing = frame length + 18 cycles.
- Round-robin wrap: after a grant to 3, req=4'b1001 -> requester 0 granted, then 3.
- Timeout: stub holds tx_busy=0 -> err_timeout pulses exactly 64 cycles after tx_start and state returns to IDLE. With no req pending the next cycle, sched_busy=0.
- Reset mid-frame: assert rst_top in WAIT_DONE -> outputs reset immediately. After release with req=4'b0100, requester 2 is granted first.
